fetch_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives the 8-bit address into instruction memory. Memory returns the 16-bit instruction combinationally in the same cycle.
- Registers the returned instruction into the IF/ID pipeline register for the decoder.
- Handles start, stall, branch redirect and HALT sequencing, and keeps a fetched-instruction count.

---
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage that owns the program counter.
//   The PC drives the instruction-memory address. The memory returns the
//   instruction combinationally, and this stage registers it into the
//   IF/ID pipeline register. The stage sequences start, stall, branch
//   redirect and HALT, and counts the instructions it fetches.
//
// Build option:
//   BRANCH_FLUSH_EN - when defined, a taken branch squashes the IF/ID
//                     register to a NOP with if_valid=0. When undefined,
//                     IF/ID follows the normal stall/capture rule on a
//                     branch edge.
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   start          begin fetching (IDLE) or restart (HALT)
//   stall          hold the PC and IF/ID (decoder not ready)
//   branch_taken   redirect request from the execute stage
//   branch_target  new PC when branch_taken=1
//   add            instruction-memory address (the PC register)
//   inst           instruction read from memory at add, same cycle
//   if_inst        IF/ID instruction (16'h0000 = NOP)
//   if_pc          address that if_inst was fetched from
//   if_valid       if_inst holds a real fetched instruction
//   halted         stage is in HALT
//   fcount         saturating count of captured instructions
module fetch_stage #(
  parameter int unsigned     AW       = 8,
  parameter int unsigned     DW       = 16,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter logic [2:0]      HALT_OP  = 3'b111
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic [AW-1:0] add,
  input  logic [DW-1:0] inst,
  output logic [DW-1:0] if_inst,
  output logic [AW-1:0] if_pc,
  output logic          if_valid,
  output logic          halted,
  output logic [15:0]   fcount
);

  localparam int unsigned CW = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] if_inst_q, if_inst_d;
  logic [AW-1:0] if_pc_q, if_pc_d;
  logic          if_valid_q, if_valid_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] fcount_q, fcount_d;
  logic          capture_c;
  logic          is_halt_c;

  assign is_halt_c = (inst[DW-1 -: 3] == HALT_OP);

  // Next-state and IF/ID update logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    halted_d   = halted_q;
    fcount_d   = fcount_q;
    capture_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end

      S_RUN: begin
        if (branch_taken) begin
          // Branch redirects the PC even while the decoder stalls
          pc_d = branch_target;
`ifdef BRANCH_FLUSH_EN
          if_inst_d  = '0;
          if_valid_d = 1'b0;
          if_pc_d    = pc_q;
`else
          if (!stall) capture_c = 1'b1;
`endif
        end else if (!stall) begin
          capture_c = 1'b1;
          if (is_halt_c) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end

      S_HALT: begin
        // HALT instruction stays in IF/ID until the decoder accepts it
        if (!stall) begin
          if_inst_d  = '0;
          if_valid_d = 1'b0;
        end
        if (start) begin
          pc_d     = RESET_PC;
          halted_d = 1'b0;
          state_d  = S_RUN;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (capture_c) begin
      if_inst_d  = inst;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      if (fcount_q != {CW{1'b1}}) fcount_d = fcount_q + CW'(1);
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      fcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
      fcount_q   <= fcount_d;
    end
  end

  assign add      = pc_q;
  assign if_inst  = if_inst_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;
  assign halted   = halted_q;
  assign fcount   = fcount_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage. The bench runs
//   directed scenarios and then randomized start/stall/branch traffic
//   against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] add;
  logic [DW-1:0] inst;
  logic [DW-1:0] if_inst;
  logic [AW-1:0] if_pc;
  logic          if_valid;
  logic          halted;
  logic [15:0]   fcount;

  logic [DW-1:0] mem [256];

  int n_checks;
  int n_errors;

  // Behavioural model: 0 idle, 1 run, 2 halt
  int            m_state;
  int            m_pc;
  logic [DW-1:0] m_if_inst;
  int            m_if_pc;
  logic          m_if_valid;
  logic          m_halted;
  int            m_fcount;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .add           (add),
    .inst          (inst),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .halted        (halted),
    .fcount        (fcount)
  );

  assign inst = mem[add];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state    = 0;
    m_pc       = 0;
    m_if_inst  = '0;
    m_if_pc    = 0;
    m_if_valid = 1'b0;
    m_halted   = 1'b0;
    m_fcount   = 0;
  endtask

  task automatic model_capture(input logic [DW-1:0] w);
    m_if_inst  = w;
    m_if_pc    = m_pc;
    m_if_valid = 1'b1;
    if (m_fcount < 65535) m_fcount = m_fcount + 1;
  endtask

  // One rising edge of the fetch rules
  task automatic model_step(input logic st, input logic sl, input logic br, input logic [AW-1:0] tgt);
    logic [DW-1:0] w;
    w = mem[m_pc];
    if (m_state == 0) begin
      if (st) m_state = 1;
    end else if (m_state == 1) begin
      if (br) begin
`ifdef BRANCH_FLUSH_EN
        m_if_inst  = '0;
        m_if_valid = 1'b0;
        m_if_pc    = m_pc;
`else
        if (!sl) model_capture(w);
`endif
        m_pc = int'(tgt);
      end else if (!sl) begin
        model_capture(w);
        if (w[15:13] == 3'b111) begin
          m_state  = 2;
          m_halted = 1'b1;
        end else begin
          m_pc = (m_pc + 1) % 256;
        end
      end
    end else begin
      if (!sl) begin
        m_if_inst  = '0;
        m_if_valid = 1'b0;
      end
      if (st) begin
        m_pc     = 0;
        m_halted = 1'b0;
        m_state  = 1;
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".add"},      32'(add),      32'(m_pc));
    chk({ph, ".if_inst"},  32'(if_inst),  32'(m_if_inst));
    chk({ph, ".if_pc"},    32'(if_pc),    32'(m_if_pc));
    chk({ph, ".if_valid"}, 32'(if_valid), 32'(m_if_valid));
    chk({ph, ".halted"},   32'(halted),   32'(m_halted));
    chk({ph, ".fcount"},   32'(fcount),   32'(m_fcount));
  endtask

  // Called at a falling edge: drive, advance model, clock, compare
  task automatic cyc(input logic st, input logic sl, input logic br, input logic [AW-1:0] tgt);
    start         = st;
    stall         = sl;
    branch_taken  = br;
    branch_target = tgt;
    model_step(st, sl, br, tgt);
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic fill_mem(input int halt_pct);
    for (int a = 0; a < 256; a++) begin
      logic [DW-1:0] w;
      w = DW'($urandom);
      if (w[15:13] == 3'b111 && $urandom_range(0, 99) >= halt_pct) w[15] = 1'b0;
      mem[a] = w;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;

    fill_mem(0);
    for (int a = 0; a < 5; a++) mem[a] = 16'h2001 + DW'(a);
    mem[5]    = 16'h3005;
    mem[6]    = 16'h3006;
    mem[7]    = 16'hE000;
    mem[8'h40] = 16'h4040;
    mem[8'h41] = 16'h4041;
    mem[8'h42] = 16'h4042;
    mem[8'h43] = 16'hE000;
    mem[8'hFE] = 16'h50FE;
    mem[8'hFF] = 16'h50FF;

    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Start: nothing captured on the start edge
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("start_add", 32'(add), 32'h0);
    chk("start_valid", 32'(if_valid), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("first_inst", 32'(if_inst), 32'h2001);
    chk("first_add", 32'(add), 32'h1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, '0);

    // Stall three cycles at add=3
    repeat (3) cyc(1'b0, 1'b1, 1'b0, '0);
    chk("stall_add", 32'(add), 32'h3);
    chk("stall_inst", 32'(if_inst), 32'h2003);
    chk("stall_fcount", 32'(fcount), 32'd3);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, '0);
    chk("five_fcount", 32'(fcount), 32'd5);
    chk("five_inst", 32'(if_inst), 32'h2005);

    // Branch at add=5 to 0x40
    cyc(1'b0, 1'b0, 1'b1, 8'h40);
    chk("br_add", 32'(add), 32'h40);
`ifdef BRANCH_FLUSH_EN
    chk("br_valid", 32'(if_valid), 32'h0);
    chk("br_inst", 32'(if_inst), 32'h0);
`else
    chk("br_valid", 32'(if_valid), 32'h1);
    chk("br_inst", 32'(if_inst), 32'h3005);
`endif

    // Run into HALT at 0x43
    repeat (4) cyc(1'b0, 1'b0, 1'b0, '0);
    chk("halt_inst", 32'(if_inst), 32'hE000);
    chk("halt_add", 32'(add), 32'h43);
    chk("halt_flag", 32'(halted), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 8'h10);
    chk("halt_nop", 32'(if_valid), 32'h0);
    chk("halt_nobr", 32'(add), 32'h43);

    // Restart and run into HALT at 7
    cyc(1'b1, 1'b0, 1'b0, '0);
    chk("restart_add", 32'(add), 32'h0);
    chk("restart_halted", 32'(halted), 32'h0);
    repeat (8) cyc(1'b0, 1'b0, 1'b0, '0);
    chk("halt7_add", 32'(add), 32'h7);
    chk("halt7_flag", 32'(halted), 32'h1);

    // Wrap 0xFF -> 0x00
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 8'hFE);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, '0);
    chk("wrap_add", 32'(add), 32'h0);
    chk("wrap_if_pc", 32'(if_pc), 32'hFF);

    // Asynchronous reset between edges
    start = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0);
    chk("idle_add", 32'(add), 32'h0);
    chk("idle_valid", 32'(if_valid), 32'h0);

    // Randomized traffic with occasional HALT opcodes
    fill_mem(40);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) == 0, AW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
